// File: rtl/switch_pkg.sv
// Shared types, CC descriptor layout and packing helper for the DSP-side config completion path.
package switch_pkg;

  typedef enum logic [3:0] {
    REQ_MRD    = 4'b0000,
    REQ_MWR    = 4'b0001,
    REQ_IORD   = 4'b0010,
    REQ_IOWR   = 4'b0011,
    REQ_CFGRD0 = 4'b1000,
    REQ_CFGWR0 = 4'b1001,
    REQ_CFGRD1 = 4'b1010,
    REQ_CFGWR1 = 4'b1011,
    REQ_MSG    = 4'b1100,
    REQ_MSG_VD = 4'b1101
  } req_type_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CPL = 2'd1,
    ST_SEND     = 2'd2
  } cpl_state_t;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  localparam int CC_LOWER_ADDR  = 0;
  localparam int CC_BYTE_COUNT  = 16;
  localparam int CC_DWORD_COUNT = 32;
  localparam int CC_STATUS      = 43;
  localparam int CC_REQ_ID      = 48;
  localparam int CC_TAG         = 64;
  localparam int CC_CPL_ID      = 72;
  localparam int CC_CPL_ID_EN   = 88;
  localparam int CC_TC          = 89;
  localparam int CC_ATTR        = 92;

  function automatic logic is_posted(input logic [3:0] t);
    return (t == REQ_MWR) || (t[3:2] == 2'b11);
  endfunction

  function automatic logic is_cfg_rd(input logic [3:0] t);
    return (t == REQ_CFGRD0) || (t == REQ_CFGRD1);
  endfunction

  // AT, poison, ECRC and locked stay zero along with every reserved bit.
  function automatic logic [95:0] pack_cc_desc(
    input logic [6:0]  lower_addr,
    input logic [12:0] byte_count,
    input logic [10:0] dword_count,
    input logic [2:0]  status,
    input logic [15:0] requester_id,
    input logic [7:0]  tag,
    input logic [15:0] completer_id,
    input logic [2:0]  tc,
    input logic [2:0]  attr
  );
    logic [95:0] d;
    d = '0;
    d[CC_LOWER_ADDR  +: 7]  = lower_addr;
    d[CC_BYTE_COUNT  +: 13] = byte_count;
    d[CC_DWORD_COUNT +: 11] = dword_count;
    d[CC_STATUS      +: 3]  = status;
    d[CC_REQ_ID      +: 16] = requester_id;
    d[CC_TAG         +: 8]  = tag;
    d[CC_CPL_ID      +: 16] = completer_id;
    d[CC_CPL_ID_EN]         = 1'b1;
    d[CC_TC          +: 3]  = tc;
    d[CC_ATTR        +: 3]  = attr;
    return d;
  endfunction

endpackage

// File: rtl/switch_cfg_cpl_generator.sv
// Builds one single-beat CC completion per non-posted request; tvalid rises one cycle after cpl_send
// and holds with stable payload under backpressure; req_ready returns one cycle after the handshake.
module switch_cfg_cpl_generator
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int TUSER_WIDTH = 81
) (
  input  logic                    dsp_user_clk,
  input  logic                    dsp_user_reset,
  input  logic                    usp_user_reset_dsp_domain,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_type,
  input  logic [15:0]             req_requester_id,
  input  logic [7:0]              req_tag,
  input  logic [2:0]              req_tc,
  input  logic [2:0]              req_attr,
  input  logic [6:0]              req_lower_addr,
  input  logic [15:0]             completer_id,
  input  logic                    cpl_send,
  input  logic                    cpl_ur,
  input  logic [31:0]             cpl_data,
  output logic [DATA_WIDTH-1:0]   m_axis_cpl_tdata,
  output logic [DATA_WIDTH/32-1:0] m_axis_cpl_tkeep,
  output logic                    m_axis_cpl_tlast,
  output logic [TUSER_WIDTH-1:0]  m_axis_cpl_tuser,
  output logic                    m_axis_cpl_tvalid,
  input  logic                    m_axis_cpl_tready,
  output logic                    err_orphan_cpl
);

  cpl_state_t  state_q, state_d;
  logic        err_q, err_d;
  logic        cap_req, cap_cpl;
  logic [3:0]  type_q;
  logic [15:0] rid_q, cid_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q, attr_q;
  logic [6:0]  la_q;
  logic        ur_q;
  logic [31:0] data_q;
  logic        send_cpld;
  logic [95:0] desc;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cap_req = 1'b0;
    cap_cpl = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && !is_posted(req_type)) begin
          cap_req = 1'b1;
          cap_cpl = cpl_send;
          state_d = cpl_send ? ST_SEND : ST_WAIT_CPL;
        end else if (cpl_send) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT_CPL: begin
        if (cpl_send) begin
          cap_cpl = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cpl_send) err_d = 1'b1;
        if (m_axis_cpl_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flush from the USP domain has exactly the same effect as local reset, including dropping a pending beat.
  always_ff @(posedge dsp_user_clk) begin
    if (dsp_user_reset || usp_user_reset_dsp_domain) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      type_q  <= '0;
      rid_q   <= '0;
      cid_q   <= '0;
      tag_q   <= '0;
      tc_q    <= '0;
      attr_q  <= '0;
      la_q    <= '0;
      ur_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cap_req) begin
        type_q <= req_type;
        rid_q  <= req_requester_id;
        cid_q  <= completer_id;
        tag_q  <= req_tag;
        tc_q   <= req_tc;
        attr_q <= req_attr;
        la_q   <= req_lower_addr;
      end
      if (cap_cpl) begin
        ur_q   <= cpl_ur;
        data_q <= cpl_data;
      end
    end
  end

  assign send_cpld = !ur_q && is_cfg_rd(type_q);
  assign desc = pack_cc_desc(la_q, 13'd4, send_cpld ? 11'd1 : 11'd0, ur_q ? CPL_UR : CPL_SC,
                             rid_q, tag_q, cid_q, tc_q, attr_q);

  always_comb begin
    m_axis_cpl_tdata = '0;
    m_axis_cpl_tkeep = '0;
    if (state_q == ST_SEND) begin
      m_axis_cpl_tdata[127:0] = {send_cpld ? data_q : 32'h0, desc};
      m_axis_cpl_tkeep[3:0]   = send_cpld ? 4'hF : 4'h7;
    end
  end

  assign m_axis_cpl_tvalid = (state_q == ST_SEND);
  assign m_axis_cpl_tlast  = (state_q == ST_SEND);
  assign m_axis_cpl_tuser  = '0;
  assign req_ready         = (state_q == ST_IDLE);
  assign err_orphan_cpl    = err_q;

endmodule

// File: tb/tb_switch_cfg_cpl_generator.sv
// Directed bench for switch_cfg_cpl_generator; expected beats are built from the CC field layout.
module tb_switch_cfg_cpl_generator;

  localparam int DW = 512;
  localparam int UW = 81;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          req_valid, req_ready;
  logic [3:0]    req_type;
  logic [15:0]   req_rid, cid;
  logic [7:0]    req_tag;
  logic [2:0]    req_tc, req_attr;
  logic [6:0]    req_la;
  logic          cpl_send, cpl_ur;
  logic [31:0]   cpl_data;
  logic [DW-1:0] tdata;
  logic [DW/32-1:0] tkeep;
  logic          tlast, tvalid, tready, err;
  logic [UW-1:0] tuser;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_b;

  always #5 clk = ~clk;

  switch_cfg_cpl_generator #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .dsp_user_clk(clk), .dsp_user_reset(rst), .usp_user_reset_dsp_domain(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_requester_id(req_rid), .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
    .req_lower_addr(req_la), .completer_id(cid), .cpl_send(cpl_send), .cpl_ur(cpl_ur),
    .cpl_data(cpl_data), .m_axis_cpl_tdata(tdata), .m_axis_cpl_tkeep(tkeep),
    .m_axis_cpl_tlast(tlast), .m_axis_cpl_tuser(tuser), .m_axis_cpl_tvalid(tvalid),
    .m_axis_cpl_tready(tready), .err_orphan_cpl(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input logic [6:0] la, input logic [2:0] st,
                                        input logic [10:0] dwc, input logic [15:0] rid,
                                        input logic [7:0] tg, input logic [15:0] c,
                                        input logic [2:0] tc, input logic [2:0] at,
                                        input logic [31:0] pl);
    return {pl, 1'b0, at, tc, 1'b1, c, tg, rid, 2'b00, st, dwc, 3'b000, 13'd4, 9'd0, la};
  endfunction

  task automatic set_req(input logic [3:0] t, input logic [15:0] rid, input logic [7:0] tg,
                         input logic [2:0] tc, input logic [2:0] at, input logic [6:0] la);
    req_valid = 1'b1; req_type = t; req_rid = rid; req_tag = tg;
    req_tc = tc; req_attr = at; req_la = la;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_type = '0; req_rid = '0; req_tag = '0;
    req_tc = '0; req_attr = '0; req_la = '0; cid = 16'h0300; cpl_send = 1'b0; cpl_ur = 1'b0;
    cpl_data = '0; tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_tvalid", 128'(tvalid), 128'd1 - 128'd1);
    check("rst_req_ready", 128'(req_ready), 128'd1);
    check("rst_err", 128'(err), 128'd0);
    check("rst_tdata", 128'(tdata != '0), 128'd0);
    check("rst_tkeep_tlast", 128'({tkeep, tlast}), 128'd0);
    tick();

    // Cfg read type 1010, completion data returned as CplD
    set_req(4'b1010, 16'h0100, 8'h2A, 3'd0, 3'd0, 7'h00);
    tick();
    req_valid = 1'b0;
    check("rd_wait_req_ready", 128'(req_ready), 128'd0);
    check("rd_wait_tvalid", 128'(tvalid), 128'd0);
    cpl_send = 1'b1; cpl_data = 32'h1234_10EE; cpl_ur = 1'b0;
    tick();
    cpl_send = 1'b0;
    check("rd_tvalid", 128'(tvalid), 128'd1);
    check("rd_tlast", 128'(tlast), 128'd1);
    check("rd_tkeep", 128'(tkeep), 128'hF);
    check("rd_dword_count", 128'(tdata[42:32]), 128'd1);
    check("rd_payload", 128'(tdata[127:96]), 128'h1234_10EE);
    exp_b = beat(7'h00, 3'b000, 11'd1, 16'h0100, 8'h2A, 16'h0300, 3'd0, 3'd0, 32'h1234_10EE);
    check("rd_beat", tdata[127:0], exp_b);
    check("rd_upper_zero", 128'(tdata[DW-1:128] != '0), 128'd0);
    check("rd_tuser", 128'(tuser != '0), 128'd0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("rd_done_tvalid", 128'(tvalid), 128'd0);
    check("rd_done_req_ready", 128'(req_ready), 128'd1);

    // Cfg write type 1011: Cpl without data, returned data must be ignored
    cid = 16'h0518;
    set_req(4'b1011, 16'hABCD, 8'h5C, 3'd5, 3'd2, 7'h00);
    tick();
    req_valid = 1'b0; cid = 16'hFFFF;
    cpl_send = 1'b1; cpl_data = 32'hDEAD_BEEF; cpl_ur = 1'b0;
    tick();
    cpl_send = 1'b0;
    exp_b = beat(7'h00, 3'b000, 11'd0, 16'hABCD, 8'h5C, 16'h0518, 3'd5, 3'd2, 32'h0);
    check("wr_tvalid", 128'(tvalid), 128'd1);
    check("wr_beat", tdata[127:0], exp_b);
    check("wr_tag", 128'(tdata[71:64]), 128'h5C);
    check("wr_byte_count", 128'(tdata[28:16]), 128'd4);
    check("wr_tkeep", 128'(tkeep), 128'h7);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("wr_done_tvalid", 128'(tvalid), 128'd0);

    // MRd with UR, request and cpl_send in the same cycle, then backpressure
    cid = 16'h0300;
    set_req(4'b0000, 16'h0042, 8'h07, 3'd1, 3'd4, 7'h44);
    cpl_send = 1'b1; cpl_ur = 1'b1; cpl_data = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0; cpl_send = 1'b0; cpl_ur = 1'b0;
    exp_b = beat(7'h44, 3'b001, 11'd0, 16'h0042, 8'h07, 16'h0300, 3'd1, 3'd4, 32'h0);
    check("ur_tvalid", 128'(tvalid), 128'd1);
    check("ur_status", 128'(tdata[45:43]), 128'd1);
    check("ur_lower_addr", 128'(tdata[6:0]), 128'h44);
    check("ur_tkeep", 128'(tkeep), 128'h7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_tvalid", 128'(tvalid), 128'd1);
      check("bp_beat", tdata[127:0], exp_b);
      check("bp_req_ready", 128'(req_ready), 128'd0);
    end
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("bp_done_tvalid", 128'(tvalid), 128'd0);
    check("bp_done_req_ready", 128'(req_ready), 128'd1);
    check("bp_err_clear", 128'(err), 128'd0);

    // Posted MWr is ignored; the following cpl_send is an orphan
    set_req(4'b0001, 16'h1111, 8'h11, 3'd0, 3'd0, 7'h10);
    tick();
    req_valid = 1'b0;
    check("mwr_req_ready", 128'(req_ready), 128'd1);
    cpl_send = 1'b1; cpl_data = 32'h0BAD_0BAD;
    tick();
    cpl_send = 1'b0;
    tick();
    check("mwr_no_beat", 128'(tvalid), 128'd0);
    check("mwr_orphan_err", 128'(err), 128'd1);

    // Flush while a beat is pending drops it and clears the sticky error
    set_req(4'b1000, 16'h0200, 8'h33, 3'd0, 3'd0, 7'h00);
    cpl_send = 1'b1; cpl_data = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0; cpl_send = 1'b0;
    check("fl_pre_tvalid", 128'(tvalid), 128'd1);
    check("fl_pre_err", 128'(err), 128'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_tvalid", 128'(tvalid), 128'd0);
    check("fl_tlast", 128'(tlast), 128'd0);
    check("fl_req_ready", 128'(req_ready), 128'd1);
    check("fl_err", 128'(err), 128'd0);
    check("fl_tdata", 128'(tdata != '0), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
